// File: rtl/systolic_feeder_if.sv
// Operand-feed bundle between the matrix source, the feeder and the MAC array.
// The master side supplies matrices and start; the feeder (slave) returns the skewed stream.
interface systolic_feeder_if #(
  parameter int OP_WIDTH = 8,
  parameter int DIM      = 2
);
  logic                          start;
  logic [DIM*DIM*OP_WIDTH-1:0]   a_matrix;
  logic [DIM*DIM*OP_WIDTH-1:0]   b_matrix;
  logic [DIM*OP_WIDTH-1:0]       new_a_column;
  logic [DIM*OP_WIDTH-1:0]       new_b_row;
  logic                          feed_valid;
  logic                          acc_clear;
  logic                          busy;
  logic                          done;

  modport master (
    output start, a_matrix, b_matrix,
    input  new_a_column, new_b_row, feed_valid, acc_clear, busy, done
  );

  modport slave (
    input  start, a_matrix, b_matrix,
    output new_a_column, new_b_row, feed_valid, acc_clear, busy, done
  );
endinterface

// File: rtl/systolic_feeder.sv
// Operand sequencer for a DIM x DIM systolic MAC array: latches A and B on start,
// then streams skewed A columns / B rows, pads with zeros, drains and pulses done.
module systolic_feeder #(
  parameter int OP_WIDTH = 8,
  parameter int DIM      = 2
) (
  input logic             clk,
  input logic             reset,
  systolic_feeder_if.slave bus
);
  localparam int MAT_W = DIM*DIM*OP_WIDTH;
  localparam int VEC_W = DIM*OP_WIDTH;
  localparam int CNT_W = $clog2(2*DIM);
  localparam logic [CNT_W-1:0] LAST_FEED  = CNT_W'(2*DIM-2);
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(DIM-1);

  typedef enum logic [2:0] {IDLE, LOAD, FEED, DRAIN, DONE} state_t;

  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt, next_cnt;
  logic [MAT_W-1:0]   a_lat, b_lat;
  logic [VEC_W-1:0]   a_col_d, b_row_d;
  logic               feed_d, clear_d, busy_d, done_d;
  int                 t;

  // State and step counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_lat <= '0;
      b_lat <= '0;
    end else if (state == IDLE && bus.start) begin
      a_lat <= bus.a_matrix;
      b_lat <= bus.b_matrix;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      IDLE: if (bus.start) next_state = LOAD;
      LOAD: begin
        next_state = FEED;
        next_cnt   = '0;
      end
      FEED: begin
        if (cnt == LAST_FEED) begin
          next_state = DRAIN;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == LAST_DRAIN) begin
          next_state = DONE;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      DONE: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so the registered copy lines up with it.
  // Row i and column j share the skew index t-i, so one loop builds both vectors.
  always_comb begin
    a_col_d = '0;
    b_row_d = '0;
    t       = int'(next_cnt);
    feed_d  = (next_state == FEED);
    clear_d = (next_state == LOAD);
    busy_d  = (next_state != IDLE);
    done_d  = (next_state == DONE);
    if (feed_d) begin
      for (int i = 0; i < DIM; i++) begin
        if (t >= i && t - i < DIM) begin
          a_col_d[i*OP_WIDTH +: OP_WIDTH] = a_lat[(i*DIM + t - i)*OP_WIDTH +: OP_WIDTH];
          b_row_d[i*OP_WIDTH +: OP_WIDTH] = b_lat[((t - i)*DIM + i)*OP_WIDTH +: OP_WIDTH];
        end
      end
    end
  end

  // Output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.new_a_column <= '0;
      bus.new_b_row    <= '0;
      bus.feed_valid   <= 1'b0;
      bus.acc_clear    <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
    end else begin
      bus.new_a_column <= a_col_d;
      bus.new_b_row    <= b_row_d;
      bus.feed_valid   <= feed_d;
      bus.acc_clear    <= clear_d;
      bus.busy         <= busy_d;
      bus.done         <= done_d;
    end
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder (DIM=2 and DIM=3 instances) with a
// cycle-timeline reference model and a behavioural 2x2 MAC array on the DIM=2 stream.
module tb_systolic_feeder;
  logic clk;
  logic reset;

  systolic_feeder_if #(.OP_WIDTH(8), .DIM(2)) if2 ();
  systolic_feeder_if #(.OP_WIDTH(8), .DIM(3)) if3 ();

  systolic_feeder #(.OP_WIDTH(8), .DIM(2)) dut2 (.clk(clk), .reset(reset), .bus(if2));
  systolic_feeder #(.OP_WIDTH(8), .DIM(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  typedef struct {
    logic [15:0] acol;
    logic [15:0] brow;
    logic        fv;
    logic        ac;
    logic        busy;
    logic        done;
  } vec_t;
  vec_t tbl [8];

  int ex_a [3][3];
  int ex_b [3][3];
  int id_a [3][3];
  int nine [3][3];
  int a3   [3][3];
  int b3   [3][3];
  int ra   [3][3];
  int rb   [3][3];

  // Behavioural 2x2 output-stationary array fed by dut2
  int acc [2][2];
  int ar  [2][2];
  int br  [2][2];

  function automatic int ain(int i, int j);
    if (j == 0) return int'(if2.new_a_column[i*8 +: 8]);
    return ar[i][j-1];
  endfunction

  function automatic int bin(int i, int j);
    if (i == 0) return int'(if2.new_b_row[j*8 +: 8]);
    return br[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        if (if2.acc_clear) begin
          acc[i][j] <= 0;
          ar[i][j]  <= 0;
          br[i][j]  <= 0;
        end else begin
          acc[i][j] <= acc[i][j] + ain(i, j) * bin(i, j);
          ar[i][j]  <= ain(i, j);
          br[i][j]  <= bin(i, j);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      passes++;
    end
  endtask

  // Expected outputs c cycles after the accepting edge, from the run timeline:
  // c=1 clear, c=2..2d feed step t=c-2, busy for c=1..3d+1, done at c=3d+1.
  function automatic logic [51:0] model(input int d, input int c,
                                        input int a [3][3], input int b [3][3]);
    logic [23:0] av, bv;
    logic fv;
    int t;
    av = '0;
    bv = '0;
    t  = c - 2;
    fv = (c >= 2 && c <= 2*d);
    if (fv) begin
      for (int i = 0; i < d; i++) begin
        if (t - i >= 0 && t - i < d) begin
          av[i*8 +: 8] = 8'(a[i][t-i]);
          bv[i*8 +: 8] = 8'(b[t-i][i]);
        end
      end
    end
    return {av, bv, fv, (c == 1), (c >= 1 && c <= 3*d+1), (c == 3*d+1)};
  endfunction

  function automatic logic [51:0] act2();
    return {8'h00, if2.new_a_column, 8'h00, if2.new_b_row,
            if2.feed_valid, if2.acc_clear, if2.busy, if2.done};
  endfunction

  function automatic logic [51:0] act3();
    return {if3.new_a_column, if3.new_b_row,
            if3.feed_valid, if3.acc_clear, if3.busy, if3.done};
  endfunction

  function automatic logic [31:0] flat2(input int m [3][3]);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 2; k++)
        v[(i*2+k)*8 +: 8] = 8'(m[i][k]);
    return v;
  endfunction

  function automatic logic [71:0] flat3(input int m [3][3]);
    logic [71:0] v;
    v = '0;
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 3; k++)
        v[(i*3+k)*8 +: 8] = 8'(m[i][k]);
    return v;
  endfunction

  // One DIM=2 run; with hold, start stays high and the inputs churn every cycle.
  task automatic run2(input int a [3][3], input int b [3][3], input bit hold, input string nm);
    int cexp;
    @(negedge clk);
    if2.a_matrix = flat2(a);
    if2.b_matrix = flat2(b);
    if2.start    = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (hold) begin
        if2.a_matrix = $urandom;
        if2.b_matrix = $urandom;
      end else begin
        if2.start = 1'b0;
      end
      chk($sformatf("%s c%0d", nm, c), act2(), model(2, c, a, b));
      if (c == 7) begin
        for (int i = 0; i < 2; i++) begin
          for (int j = 0; j < 2; j++) begin
            cexp = a[i][0]*b[0][j] + a[i][1]*b[1][j];
            chk($sformatf("%s mac c%0d%0d", nm, i, j), 64'(acc[i][j]), 64'(cexp));
          end
        end
      end
    end
    if2.start = 1'b0;
  endtask

  initial begin
    int busy_cnt;

    ex_a = '{'{1, 2, 0}, '{3, 4, 0}, '{0, 0, 0}};
    ex_b = '{'{5, 6, 0}, '{7, 8, 0}, '{0, 0, 0}};
    id_a = '{'{1, 0, 0}, '{0, 1, 0}, '{0, 0, 0}};
    nine = '{'{9, 9, 0}, '{9, 9, 0}, '{0, 0, 0}};
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 3; k++) begin
        a3[i][k] = 10*i + k;
        b3[i][k] = 10*i + k + 1;
      end
    end

    tbl[0] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{16'h0001, 16'h0005, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{16'h0302, 16'h0607, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{16'h0400, 16'h0800, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};

    reset        = 1'b0;
    if2.start    = 1'b0;
    if2.a_matrix = '0;
    if2.b_matrix = '0;
    if3.start    = 1'b0;
    if3.a_matrix = '0;
    if3.b_matrix = '0;

    // Reset with start held high: nothing may start.
    #1 reset = 1'b1;
    if2.start = 1'b1;
    if3.start = 1'b1;
    #2 chk("reset async dim2", act2(), '0);
    chk("reset async dim3", act3(), '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("reset hold c%0d", c), act2(), '0);
    end
    reset     = 1'b0;
    if2.start = 1'b0;
    if3.start = 1'b0;
    @(negedge clk);
    chk("idle after reset", act2(), '0);

    // Worked DIM=2 example from a fixed table.
    @(negedge clk);
    if2.a_matrix = flat2(ex_a);
    if2.b_matrix = flat2(ex_b);
    if2.start    = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if2.start = 1'b0;
      chk($sformatf("example c%0d", c + 1), act2(),
          {8'h00, tbl[c].acol, 8'h00, tbl[c].brow, tbl[c].fv, tbl[c].ac, tbl[c].busy, tbl[c].done});
      if (c == 6) begin
        chk("example C00", 64'(acc[0][0]), 64'd19);
        chk("example C01", 64'(acc[0][1]), 64'd22);
        chk("example C10", 64'(acc[1][0]), 64'd43);
        chk("example C11", 64'(acc[1][1]), 64'd50);
      end
    end

    // start held and matrices churned throughout; then a normal run right after.
    run2(ex_a, ex_b, 1'b1, "busy reject");
    run2(nine, ex_a, 1'b0, "after reject");

    // Reset in the middle of FEED.
    @(negedge clk);
    if2.a_matrix = flat2(ex_a);
    if2.b_matrix = flat2(ex_b);
    if2.start    = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if2.start = 1'b0;
      chk($sformatf("pre-abort c%0d", c), act2(), model(2, c, ex_a, ex_b));
    end
    #2 reset = 1'b1;
    if2.start = 1'b1;
    #1 chk("abort async zero", act2(), '0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("abort hold c%0d", c), act2(), '0);
    end
    reset     = 1'b0;
    if2.start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("no done after abort c%0d", c), act2(), '0);
    end
    run2(id_a, nine, 1'b0, "fresh identity");

    // DIM=3 run.
    @(negedge clk);
    if3.a_matrix = flat3(a3);
    if3.b_matrix = flat3(b3);
    if3.start    = 1'b1;
    busy_cnt     = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if3.start = 1'b0;
      if (if3.busy) busy_cnt++;
      chk($sformatf("dim3 c%0d", c), act3(), model(3, c, a3, b3));
      if (c == 4) chk("dim3 t2 a_col", 64'(if3.new_a_column), 64'h140B02);
    end
    chk("dim3 busy length", 64'(busy_cnt), 64'd10);

    // Randomised DIM=2 runs.
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < 3; k++) begin
          ra[i][k] = (i < 2 && k < 2) ? int'($urandom_range(0, 255)) : 0;
          rb[i][k] = (i < 2 && k < 2) ? int'($urandom_range(0, 255)) : 0;
        end
      end
      run2(ra, rb, bit'($urandom_range(0, 1)), $sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Upstream operand sequencer for the DIM x DIM systolic MAC array.
- Latches a full A matrix and a full B matrix on `start`.
- Emits one skewed A column and one skewed B row per cycle: row i of A and column j of B are delayed by i and j cycles respectively, as the array expects.
- Pads the stream with zeros, drains the array, and signals completion.

Parameters:
- OP_WIDTH, 8, operand width in bits.
- DIM, 2, array dimension (matrices are DIM x DIM); legal range 2..8.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous active-high reset.
- start  in  1  request a new multiply; sampled only in IDLE.
- a_matrix  in  DIM*DIM*OP_WIDTH  A(i,k) at bits [(i*DIM+k)*OP_WIDTH +: OP_WIDTH].
- b_matrix  in  DIM*DIM*OP_WIDTH  B(k,j) at bits [(k*DIM+j)*OP_WIDTH +: OP_WIDTH].
- new_a_column  out  DIM*OP_WIDTH  slice i = operand for array row i.
- new_b_row  out  DIM*OP_WIDTH  slice j = operand for array column j.
- feed_valid  out  1  high while a FEED step is on the outputs.
- acc_clear  out  1  one-cycle pulse; clears the array accumulators before a run.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a run.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE.
  - All outputs 0.
  - Latched matrices 0.
  - Step counter 0.
- All outputs are registered and change only on clk edges.
- States and transitions:
  - IDLE: if start = 1 at the edge, latch a_matrix and b_matrix, then go to LOAD. Otherwise stay in IDLE.
  - LOAD: exactly 1 cycle. acc_clear = 1, feed_valid = 0, operands = 0. Next state is FEED with t = 0.
  - FEED: 2*DIM-1 cycles, t = 0 .. 2*DIM-2.
    - feed_valid = 1.
    - new_a_column slice i = A(i, t-i) if 0 <= t-i < DIM, else 0.
    - new_b_row slice j = B(t-j, j) if 0 <= t-j < DIM, else 0.
    - After t = 2*DIM-2, go to DRAIN.
  - DRAIN: DIM cycles. Operands = 0, feed_valid = 0; lets the last products propagate and accumulate. Then go to DONE.
  - DONE: 1 cycle. done = 1. Next state is IDLE.
- Latency: start sampled at edge E0.
  - acc_clear is visible after E0.
  - FEED occupies the cycles after E1 .. E(2*DIM-1).
  - done is visible after edge E(3*DIM).
  - Total busy = 3*DIM+1 cycles; 7 for DIM = 2.
- Input matrices are captured only on the accepting edge. Later changes on a_matrix/b_matrix have no effect on the run in progress.
- start while busy is ignored; no queuing.
- start is accepted again the cycle after DONE, i.e. in IDLE. Minimum start-to-start interval is 3*DIM+2 cycles.
- Reset mid-run aborts immediately:
  - No done pulse.
  - Outputs go to 0.
  - A start after reset deasserts begins a fresh run.
- Step counter is $clog2(2*DIM) bits wide and is cleared on every entry to FEED and DRAIN.
- Operands pass through unsigned and unmodified; the block does no arithmetic on them.

Test Plan:
- Reset check: assert reset asynchronously between edges -> all outputs 0 immediately. Hold start = 1 during reset -> no run starts.
- DIM=2 single run: A=[[1,2],[3,4]], B=[[5,6],[7,8]], pulse start. Required sequence:
  - acc_clear for 1 cycle.
  - FEED t0: a_col {row1 = 0, row0 = 1}, b_row {col1 = 0, col0 = 5}.
  - FEED t1: a_col {3, 2}, b_row {6, 7}.
  - FEED t2: a_col {4, 0}, b_row {8, 0}.
  - 2 zero cycles.
  - done pulse; busy high for exactly 7 cycles.
- Busy rejection: assert start every cycle during a run, and change a_matrix mid-run -> outputs follow the originally latched data; exactly one done per accepted start. The next run begins only from IDLE.
- Reset mid-FEED: assert reset at t1 -> outputs 0, no done. A new start with A = I, B = [[9,9],[9,9]] -> correct fresh sequence.
- Integration with the DIM=2 MAC array (example above) -> after done, accumulators read C = [[19,22],[43,50]].
- DIM=3 run with A(i,k) = 10*i+k and B(k,j) = 10*k+j + 1:
  - 5 FEED cycles.
  - At t = 2: a_col slices {row2 = 20, row1 = 11, row0 = 2}.
  - busy lasts 10 cycles.
